// File: rtl/tpsram_stream_reader_if.sv
// SRAM read port and byte stream of the TPSRAM stream reader, bundled as one interface.
// The master modport is the reader side; the slave modport is the SRAM/stream sink side.
interface tpsram_stream_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output raddr, ren, tdata, tvalid, tlast,
        input  rd, tready
    );

    modport slave (
        input  raddr, ren, tdata, tvalid, tlast,
        output rd, tready
    );
endinterface

// File: rtl/tpsram_stream_reader.sv
// Streams LEN bytes of the 64x8 two-port SRAM, starting at BASE_ADDR, over a valid/ready link.
// Optional trailing checksum beat is built in when TPSRAM_STREAM_READER_CHECKSUM_EN is defined.
module tpsram_stream_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    tpsram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2**ADDR_W);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [LEN_W-1:0]  rd_left;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  len_sat;
    logic              ren_q;
    logic              rd_valid;
    logic [DATA_W-1:0] skid [2];
    logic [1:0]        skid_cnt;
    logic [2:0]        buffered_nxt;
    logic              start_ok, issue;
    logic              data_valid, data_pop, last_data, final_beat;
    logic              pop_skid, push, wr_sel;
    logic [DATA_W-1:0] data_head;

    assign len_sat  = (len > DEPTH) ? DEPTH : len;
    assign start_ok = (state == IDLE) && start;

    // The read landing on RD is presented directly when the skid is empty,
    // so a beat can leave the cycle its data arrives.
    assign data_valid = rd_valid || (skid_cnt != 2'd0);
    assign data_head  = (skid_cnt != 2'd0) ? skid[0] : bus.rd;
    assign last_data  = data_valid && (beats_left == LEN_W'(1));
    assign data_pop   = data_valid && bus.tready;

    // Occupancy after this edge counts the beat leaving now; the read on REN
    // becomes the in-flight one.
    assign buffered_nxt = 3'(skid_cnt) + 3'(rd_valid) - 3'(data_pop);
    assign issue        = (state == READ) && ((buffered_nxt + 3'(ren_q)) < 3'd2);

    assign pop_skid = data_pop && (skid_cnt != 2'd0);
    assign push     = rd_valid && !((skid_cnt == 2'd0) && data_pop);
    assign wr_sel   = (skid_cnt == 2'd2) || ((skid_cnt == 2'd1) && !pop_skid);

`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
    logic              csum_pend;
    logic [DATA_W-1:0] sum;

    assign bus.tvalid = data_valid || csum_pend;
    assign bus.tdata  = csum_pend ? (DATA_W'(0) - sum) : (data_valid ? data_head : '0);
    assign bus.tlast  = csum_pend;
    assign final_beat = csum_pend && bus.tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csum_pend <= 1'b0;
            sum       <= '0;
        end else if (start_ok) begin
            csum_pend <= (len == '0);
            sum       <= '0;
        end else if (data_pop) begin
            sum <= sum + data_head;
            if (last_data) csum_pend <= 1'b1;
        end else if (final_beat) begin
            csum_pend <= 1'b0;
        end
    end
`else
    assign bus.tvalid = data_valid;
    assign bus.tdata  = data_valid ? data_head : '0;
    assign bus.tlast  = last_data;
    assign final_beat = data_pop && last_data;
`endif

    assign bus.ren   = ren_q;
    assign bus.raddr = raddr_q;
    assign busy      = (state == READ) || (state == DRAIN);
    assign done      = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: next state is defaulted before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) begin
`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
                state_nxt = (len == '0) ? DRAIN : READ;
`else
                state_nxt = (len == '0) ? FIN : READ;
`endif
            end
            READ:  if (issue && (rd_left == LEN_W'(1))) state_nxt = DRAIN;
            DRAIN: if (final_beat) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            raddr_q    <= '0;
            rd_left    <= '0;
            beats_left <= '0;
            ren_q      <= 1'b0;
            rd_valid   <= 1'b0;
            skid_cnt   <= 2'd0;
        end else begin
            ren_q    <= issue;
            rd_valid <= ren_q;
            skid_cnt <= skid_cnt + 2'(push) - 2'(pop_skid);
            if (start_ok) begin
                addr_q     <= base_addr;
                rd_left    <= len_sat;
                beats_left <= len_sat;
            end else begin
                if (issue) begin
                    raddr_q <= addr_q;
                    addr_q  <= addr_q + ADDR_W'(1);
                    rd_left <= rd_left - LEN_W'(1);
                end
                if (data_pop) beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

    // NOTE: skid entries carry no reset; skid_cnt alone says which are valid.
    always_ff @(posedge clk) begin
        if (pop_skid) skid[0] <= skid[1];
        if (push)     skid[wr_sel] <= bus.rd;
    end
endmodule

// File: tb/tb_tpsram_stream_reader.sv
// Scoreboard bench for tpsram_stream_reader: SRAM model, expected beats and read addresses
// queued at stimulus time and compared as the DUT produces them.
module tb_tpsram_stream_reader;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [5:0] base_addr = '0;
    logic [6:0] len = '0;
    logic       busy, done;

    tpsram_stream_reader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    tpsram_stream_reader #(.ADDR_W(6), .DATA_W(8), .LEN_W(7)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    always @(posedge clk) if (bus.ren) bus.rd <= mem[bus.raddr];

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [5:0] addr_exp_q[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, issued = 0, xfers = 0, last_cyc = -1, done_cnt = 0;
    int first_valid_cyc = -1, start_cyc = 0;
    int tready_mode = 0, phase = 0;
    bit stalled = 1'b0;
    logic [8:0] held;
    logic [5:0] pat = 6'b101001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 1) begin
                bus.tready = pat[phase % 6];
                phase++;
            end else begin
                bus.tready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_tvalid", bus.tvalid, 1);
                check("stall_hold", {bus.tdata, bus.tlast}, held);
            end
            if (bus.ren) begin
                check("outstanding_lt2", (issued - xfers) < 2, 1);
                issued++;
                if (addr_exp_q.size() == 0) check("ren_unexpected", bus.ren, 0);
                else check("raddr", bus.raddr, addr_exp_q.pop_front());
            end
            if (bus.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.tvalid && bus.tready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", bus.tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", bus.tdata, e.data);
                    check("tlast", bus.tlast, e.last);
                end
                xfers++;
                if (bus.tlast) last_cyc = cyc;
                stalled = 1'b0;
            end else if (bus.tvalid) begin
                stalled = 1'b1;
                held = {bus.tdata, bus.tlast};
            end else begin
                stalled = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                if (last_cyc >= 0) check("done_after_tlast", cyc - last_cyc, 1);
            end
        end
    end

    task automatic push_expect(input logic [5:0] b, input logic [6:0] l);
        int n = (l > 7'd64) ? 64 : int'(l);
        int sum = 0;
        logic [5:0] a;
        beat_t e;
        for (int i = 0; i < n; i++) begin
            a = b + 6'(i);
            addr_exp_q.push_back(a);
            e.data = mem[a];
`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (i == n - 1);
`endif
            sum += int'(mem[a]);
            exp_q.push_back(e);
        end
`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
        e.data = 8'((256 - (sum % 256)) % 256);
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    task automatic start_frame(input logic [5:0] b, input logic [6:0] l);
        issued = 0; xfers = 0; last_cyc = -1; done_cnt = 0; first_valid_cyc = -1;
        @(posedge clk);
        #1;
        base_addr = b; len = l; start = 1'b1;
        @(posedge clk);
        start_cyc = cyc + 1;
        #1;
        start = 1'b0;
        base_addr = 6'($urandom);
        len = 7'($urandom);
`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
        check("busy_after_start", busy, 1);
`else
        check("busy_after_start", busy, l != 0);
`endif
    endtask

    task automatic run_frame(input logic [5:0] b, input logic [6:0] l, input bit lat_chk,
                             input bit poke);
        push_expect(b, l);
        start_frame(b, l);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; base_addr = 6'h20; len = 7'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int k = 0; k < 600 && done_cnt == 0; k++) @(posedge clk);
        check("done_seen", done_cnt, 1);
        repeat (3) @(posedge clk);
        check("done_single_pulse", done_cnt, 1);
        check("beats_pending", exp_q.size(), 0);
        check("reads_pending", addr_exp_q.size(), 0);
        if (lat_chk) check("first_tvalid_latency", first_valid_cyc - start_cyc, 2);
        exp_q.delete();
        addr_exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tvalid", bus.tvalid, 0);
        check("rst_tlast", bus.tlast, 0);
        check("rst_tdata", bus.tdata, 0);
        check("rst_ren", bus.ren, 0);
        check("rst_raddr", bus.raddr, 0);
        resetn = 1'b1;

        run_frame(6'h00, 7'd8, 1'b1, 1'b0);
        run_frame(6'h3E, 7'd4, 1'b1, 1'b0);
        tready_mode = 1;
        run_frame(6'h00, 7'd8, 1'b0, 1'b0);
        run_frame(6'h30, 7'd40, 1'b0, 1'b0);
        tready_mode = 0;
        run_frame(6'h00, 7'd0, 1'b0, 1'b0);
        run_frame(6'h05, 7'd100, 1'b1, 1'b0);
        run_frame(6'h10, 7'd1, 1'b1, 1'b0);
        run_frame(6'h00, 7'd10, 1'b0, 1'b1);

        // Abandon a frame with reset while it is streaming.
        push_expect(6'h00, 7'd20);
        start_frame(6'h00, 7'd20);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_tvalid", bus.tvalid, 0);
        check("midrst_ren", bus.ren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        addr_exp_q.delete();
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        check("midrst_no_done", done_cnt, 0);
        run_frame(6'h08, 7'd6, 1'b1, 1'b0);

`ifdef TPSRAM_STREAM_READER_CHECKSUM_EN
        run_frame(6'h01, 7'd3, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
